// File: rtl/rv_mem_resp.sv
// Memory-side responder for the multicycle RISC-V core: one word request at a
// time, LAT wait states, then a response held until the requester takes it.
module rv_mem_resp #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          commit;
  logic          c_we;
  logic [31:0]   c_addr;
  logic [31:0]   c_wdata;
  logic [3:0]    c_be;
  logic          c_err;
  logic [AW-1:0] c_idx;

  assign req_ready  = (state == S_IDLE) && !rst;
  assign resp_valid = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    commit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LAT == 0) begin
            state_nx = S_RESP;
            commit   = 1'b1;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nx = S_RESP;
          commit   = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // With LAT=0 the commit happens on the accept edge itself, so the live
  // request fields are used instead of the (not yet loaded) latched copy.
  always_comb begin
    if (state == S_IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_be    = req_be;
    end else begin
      c_we    = we_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_be    = be_q;
    end
    c_err = (c_addr[1:0] != 2'b00) || (|c_addr[31:AW+2]);
    c_idx = c_addr[AW+1:2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt     <= CNT_INIT;
      end else if (state == S_WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end

      if (commit) begin
        resp_err   <= c_err;
        resp_rdata <= (c_err || c_we) ? '0 : mem[c_idx];
      end else if (state == S_RESP && resp_ready) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // Storage is not reset; a request dropped by reset never reaches commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && c_we && !c_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (c_be[i]) begin
          mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_rv_mem_resp.sv
// Directed bench for rv_mem_resp: LAT=2 instance for most cases, LAT=0
// instance for back-to-back traffic; expected responses go through a queue.
module tb_rv_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid1, req_ready1, req_we1;
  logic [31:0] req_addr1, req_wdata1;
  logic [3:0]  req_be1;
  logic        resp_valid1, resp_ready1, resp_err1;
  logic [31:0] resp_rdata1;

  rv_mem_resp #(.DEPTH(256), .LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  rv_mem_resp #(.DEPTH(256), .LAT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        b_we   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] b_addr [6] = '{32'h40, 32'h40, 32'h44, 32'h44, 32'h40, 32'h40};
  logic [31:0] b_wdata[6] = '{32'hA5A5A5A5, 32'h0, 32'h0F0F0F0F, 32'h0, 32'h12345678, 32'h0};
  logic [3:0]  b_be   [6] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'h3, 4'h0};
  logic [31:0] b_exp  [6] = '{32'h0, 32'hA5A5A5A5, 32'h0, 32'h0F0F0F0F, 32'h0, 32'hA5A55678};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic pop_exp(output exp_t e);
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty: observed 0 entries expected at least 1");
    end
    if (sb.size() != 0) e = sb.pop_front();
    else e = '0;
  endtask

  // One transaction on the LAT=2 instance; hold = cycles of backpressure.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input logic [31:0] exp_d, input logic exp_e, input int hold);
    exp_t e;
    int k;
    logic [31:0] d0;
    logic e0;
    sb.push_back('{d: exp_d, e: exp_e});
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF;
    req_wdata = 32'h5A5A_5A5A; req_be = 4'hF;
    k = 1;
    while (!resp_valid && k < 20) begin @(negedge clk); k++; end
    chk({tag, "_latency"}, 32'(k), 32'd3);
    d0 = resp_rdata; e0 = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_bp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "_bp_rdata"}, resp_rdata, d0);
      chk({tag, "_bp_err"}, 32'(resp_err), 32'(e0));
      chk({tag, "_bp_req_ready"}, 32'(req_ready), 32'd0);
    end
    pop_exp(e);
    chk({tag, "_rdata"}, resp_rdata, e.d);
    chk({tag, "_err"}, 32'(resp_err), 32'(e.e));
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_done_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_done_rdata"}, resp_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed simulation still running expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int issued, done, cyc, last;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    resp_ready = 1'b0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = '0;
    resp_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_valid_l0", 32'(resp_valid1), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_req_ready_l0", 32'(req_ready1), 32'd1);

    txn("wr_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
    txn("rd_full", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    txn("wr_byte0", 1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0, 0);
    txn("rd_byte0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0);
    txn("wr_be0", 1'b1, 32'h10, 32'h11223344, 4'h0, 32'h0, 1'b0, 0);
    txn("rd_be0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0);

    txn("rd_misalign", 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    txn("wr_zero", 1'b1, 32'h000, 32'h12345678, 4'hF, 32'h0, 1'b0, 0);
    txn("wr_range", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
    txn("rd_zero", 1'b0, 32'h000, 32'h0, 4'h0, 32'h12345678, 1'b0, 0);

    txn("rd_bp", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 5);

    issued = 0; done = 0; cyc = 0; last = 0;
    resp_ready1 = 1'b1;
    while (done < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (resp_valid1) begin
        pop_exp(e);
        chk("b2b_rdata", resp_rdata1, e.d);
        chk("b2b_err", 32'(resp_err1), 32'(e.e));
        if (done > 0) chk("b2b_spacing", 32'(cyc - last), 32'd2);
        last = cyc;
        done++;
      end
      if (req_ready1 && issued < 6) begin
        req_valid1 = 1'b1; req_we1 = b_we[issued]; req_addr1 = b_addr[issued];
        req_wdata1 = b_wdata[issued]; req_be1 = b_be[issued];
        sb.push_back('{d: b_exp[issued], e: 1'b0});
        issued++;
      end
    end
    req_valid1 = 1'b0;
    resp_ready1 = 1'b0;
    chk("b2b_done", 32'(done), 32'd6);

    txn("wr_0x20", 1'b1, 32'h20, 32'h11111111, 4'hF, 32'h0, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h22222222; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("abort_still_idle", 32'(resp_valid), 32'd0);
    txn("rd_0x20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11111111, 1'b0, 0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
